// File: rtl/bip_pkg.sv
// bip_pkg: shared widths, opcode encodings and program-memory states for the BIP I core.
package bip_pkg;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam logic [4:0] HLT  = 5'b00000;
    localparam logic [4:0] STO  = 5'b00001;
    localparam logic [4:0] LD   = 5'b00010;
    localparam logic [4:0] LDI  = 5'b00011;
    localparam logic [4:0] ADD  = 5'b00100;
    localparam logic [4:0] ADDI = 5'b00101;
    localparam logic [4:0] SUB  = 5'b00110;
    localparam logic [4:0] SUBI = 5'b00111;
    typedef enum logic [1:0] {INIT, LOAD, RUN} state_e;
endpackage

// File: rtl/bip_sram_1r1w.sv
// bip_sram_1r1w: one write port, one synchronous read port, no reset so it maps onto block RAM.
module bip_sram_1r1w #(
    parameter int ADDR_W = bip_pkg::ADDR_W,
    parameter int DATA_W = bip_pkg::DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/program_memory.sv
// program_memory: loads a BIP I program image over a valid/ready port, then serves
// instruction fetches with one-cycle latency, masking words beyond the loaded image.
module program_memory #(
    parameter int ADDR_W = bip_pkg::ADDR_W,
    parameter int DATA_W = bip_pkg::DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Instruction,
    input  logic              LoadValid,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              LoadLast,
    output logic              LoadReady,
    input  logic              Reload,
    output logic              CpuHold,
    output logic [ADDR_W:0]   LoadCount,
    output logic              Full
);
    import bip_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              hit_q, hit_d;
    logic              xfer, at_end;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        xfer    = (state_q == LOAD) && LoadValid;
        at_end  = cnt_q == CNT_W'(DEPTH - 1);
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        // hit_q gates the RAM read register: out-of-image or reload-cycle fetches read as HLT
        hit_d   = (state_q == RUN) && !Reload && ({1'b0, Addr} < cnt_q);
        case (state_q)
            INIT: state_d = LOAD;
            LOAD: if (xfer) begin
                cnt_d = cnt_q + 1'b1;
                if (LoadLast || at_end) state_d = RUN;
                if (!LoadLast && at_end) full_d = 1'b1;
            end
            RUN: if (Reload) begin
                state_d = LOAD;
                cnt_d   = '0;
                full_d  = 1'b0;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            hit_q   <= hit_d;
        end
    end

    bip_sram_1r1w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_sram (
        .clk_i   (Clk),
        .we_i    (xfer),
        .waddr_i (cnt_q[ADDR_W-1:0]),
        .wdata_i (LoadData),
        .raddr_i (Addr),
        .rdata_o (rdata)
    );

    assign Instruction = hit_q ? rdata : '0;
    assign LoadReady   = state_q == LOAD;
    assign CpuHold     = state_q != RUN;
    assign LoadCount   = cnt_q;
    assign Full        = full_q;
endmodule

// File: doc/program_memory.md
# program_memory

Program-memory responder for the BIP I processor: it answers the instruction fetches the `Control` unit issues on `Addr` with the 16-bit word on `Instruction`. The word format is 5-bit opcode [15:11] plus 11-bit operand [10:0]. After reset the block accepts a program image over a valid/ready load port, writing it sequentially from address 0. It then switches to run mode and serves fetches with one-cycle synchronous-read latency. At top level, `CpuHold` keeps `Control` in reset until the program is loaded.

## Interface
- `ADDR_W`, 11: fetch address width; matches `Control.Addr`.
- `DATA_W`, 16: instruction word width.
- `DEPTH`, 2048: number of words, 2**ADDR_W.
- `Clk`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `Addr`  in  ADDR_W: fetch address from `Control`.
- `Instruction`  out  DATA_W: registered fetch data to `Control`.
- `LoadValid`  in  1: load word present.
- `LoadData`  in  DATA_W: load word.
- `LoadLast`  in  1: qualifies the final word of the image; sampled with `LoadValid`.
- `LoadReady`  out  1: block accepts a load word this cycle.
- `Reload`  in  1: single-cycle pulse in run mode that requests a new load.
- `CpuHold`  out  1: high while not in run mode; holds `Control` in reset.
- `LoadCount`  out  ADDR_W+1: number of words loaded, 0..DEPTH.
- `Full`  out  1: sticky flag; the image filled memory without `LoadLast`.

## Operation
- States: INIT, LOAD and RUN. Reset forces INIT.
- INIT: `LoadReady`=0 and `CpuHold`=1. The block goes unconditionally to LOAD on the next edge.
- LOAD: `LoadReady`=1 and `CpuHold`=1.
  - A transfer occurs on an edge where `LoadValid` and `LoadReady` are both 1.
  - On a transfer, mem[`LoadCount`] <= `LoadData` and `LoadCount` increments.
  - A transfer with `LoadLast`=1 moves the block to RUN.
  - A transfer into address DEPTH-1 with `LoadLast`=0 also moves the block to RUN, and sets `Full`=1.
  - `LoadLast` without `LoadValid` is ignored.
- RUN: `LoadReady`=0 and `CpuHold`=0.
  - On every edge, `Instruction` <= (`Addr` < `LoadCount`) ? mem[`Addr`] : 16'h0000.
  - 16'h0000 is HLT, so a runaway PC halts the processor.
  - Load-port inputs are ignored.
- `Reload`=1 in RUN: the next state is LOAD. On that edge `LoadCount` <= 0, `Full` <= 0 and `Instruction` <= 0. The fetch address presented on that cycle is discarded.
- `Reload` outside RUN is ignored.
- Memory contents are not cleared by reset or `Reload`. Locations at or above `LoadCount` are masked, so stale data is never visible.
- Width rules:
  - `LoadCount` is ADDR_W+1 bits wide so that a count of DEPTH is representable.
  - The write address is `LoadCount`[ADDR_W-1:0].
  - The compare `Addr` < `LoadCount` is unsigned, with `Addr` zero-extended.

## Timing
- Reset values: `Instruction`=0, `LoadReady`=0, `CpuHold`=1, `LoadCount`=0, `Full`=0; state is INIT.
- Reset asserted mid-load or mid-run:
  - All outputs take their reset values immediately.
  - After deassertion the image must be reloaded from address 0.
- `LoadReady` and `CpuHold` are registered, decoded from the state register.
  - The first transfer can occur on the second rising edge after reset deassertion.
  - `CpuHold` falls on the same edge that accepts the last word.
- Fetch latency is 1 cycle: `Addr` at edge N gives `Instruction` valid after edge N+1.
  - `Control` already treats `Instruction` as arriving one cycle after `Addr`.
- The first RUN edge samples `Addr`, which is 0 while `Control` is held in reset.
- Throughput is one load word per cycle while `LoadValid` is held high.

## Structure
- Shared package `bip_pkg` holds:
  - ADDR_W and DATA_W;
  - the opcode constants: HLT=5'b00000, STO=00001, LD=00010, LDI=00011, ADD=00100, ADDI=00101, SUB=00110, SUBI=00111;
  - the state enum INIT/LOAD/RUN.
- One sub-module, `bip_sram_1r1w`: a single-port-write, synchronous-read array of DEPTH x DATA_W with no reset, inferable as block RAM.
- `program_memory` contains the FSM, load counter, masking compare and output register.

## Test plan
- Reset then load: pulse `Reset` low, then load 9 words 16'h0801, 0x1002, 0x1803, 0x2004, 0x3805, 0x2806, 0x3807, 0x0000, 0x0009, with `LoadLast` on the 9th. Required: `LoadCount`=9, `CpuHold` falls on the 9th accepting edge, `Full`=0.
- Fetch: in RUN, drive `Addr`=0,1,2,8. Required: `Instruction`=0x0801, 0x1002, 0x1803, 0x0009, each one edge later. `Addr`=9 and `Addr`=2047 give 0x0000.
- Backpressure and gaps: toggle `LoadValid` with 2-cycle gaps, and assert `LoadLast` with `LoadValid`=0. Required: only valid words are written, and the stray `LoadLast` is ignored.
- Full: stream 2048 words with data equal to the address, without `LoadLast`. Required: RUN entered after word 2048, `Full`=1, `LoadCount`=2048. `Addr`=2047 reads 0x07FF.
- Reload: in RUN, pulse `Reload`, then load 2 words 0xAAAA and 0x5555 with last. Required:
  - `Instruction`=0 on the `Reload` edge;
  - `Full` cleared;
  - `Addr`=2 reads 0x0000 despite the stale contents.
- Reset mid-load: assert `Reset` after 3 of 5 words. Required: outputs return to reset values at once, and after reload `LoadCount` counts from 0.
